// File: rtl/shift_pkg.sv
// Shared definitions for the ALSU shift path and its serial receive side.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } collect_state_e;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/word_out_slice.sv
// One-entry valid/ready output register; a load may coincide with a drain.
module word_out_slice #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/serial_word_collector.sv
// Assembles a serial bit stream into WIDTH-bit words, shifting left or right
// like the ALSU shift unit, and hands them out through a one-entry buffer.
module serial_word_collector
    import shift_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    input  logic             direction,
    input  logic             flush,
    output logic             word_valid,
    output logic [WIDTH-1:0] word_data,
    input  logic             word_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    collect_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             drain;
    logic             eff_dir;
    logic [WIDTH-1:0] shifted;
    logic             load;
    logic [WIDTH-1:0] load_data;

    assign bit_ready = (state_q != FULL);
    assign accept    = bit_valid && bit_ready && !flush;
    assign drain     = word_valid && word_ready;

    // The first bit of a frame uses the live direction; later bits use the latch.
    assign eff_dir = (cnt_q == '0) ? direction : dir_q;
    assign shifted = (eff_dir == DIR_LEFT) ? {asm_q[WIDTH-2:0], bit_in}
                                           : {bit_in, asm_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        dir_d     = dir_q;
        load      = 1'b0;
        load_data = shifted;
        ovf_d     = ovf_q || (bit_valid && !bit_ready && !flush);

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            asm_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (cnt_q == '0) begin
                            dir_d = direction;
                        end
                        if (cnt_q == CNT_LAST) begin
                            if (!word_valid || drain) begin
                                load    = 1'b1;
                                state_d = IDLE;
                                cnt_d   = '0;
                                asm_d   = '0;
                            end else begin
                                state_d = FULL;
                                cnt_d   = CNT_FULL;
                                asm_d   = shifted;
                            end
                        end else begin
                            state_d = COLLECT;
                            cnt_d   = cnt_q + CNT_ONE;
                            asm_d   = shifted;
                        end
                    end
                end
                FULL: begin
                    if (drain) begin
                        load      = 1'b1;
                        load_data = asm_q;
                        state_d   = IDLE;
                        cnt_d     = '0;
                        asm_d     = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    asm_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            dir_q   <= DIR_LEFT;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
        end
    end

    word_out_slice #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .data_i (load_data),
        .ready_i(word_ready),
        .valid_o(word_valid),
        .data_o (word_data)
    );

    assign bit_count = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed-vector bench for serial_word_collector (WIDTH = 6).
module tb_serial_word_collector;

    localparam int WIDTH = 6;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             direction;
    logic             flush;
    logic             word_valid;
    logic [WIDTH-1:0] word_data;
    logic             word_ready;
    logic [CNT_W-1:0] bit_count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    serial_word_collector #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .direction (direction),
        .flush     (flush),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_ready(word_ready),
        .bit_count (bit_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        step();
    endtask

    // Sends a word MSB-first in time order (element 5 is the first bit).
    task automatic send_word(input logic [5:0] w);
        for (int i = 5; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        logic [5:0]  seq6;
        logic [11:0] seq12;

        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; direction = 1'b1;
        flush = 1'b0; word_ready = 1'b0;
        @(negedge clk);
        step();
        rst = 1'b0;
        chk("rst_valid", word_valid, 0);
        chk("rst_data", word_data, 0);
        chk("rst_ready", bit_ready, 1);
        chk("rst_count", bit_count, 0);
        chk("rst_ovf", overflow, 0);

        // Left shift, consumer always ready
        word_ready = 1'b1; direction = 1'b1;
        send_word(6'b101100);
        bit_valid = 1'b0;
        chk("left_valid", word_valid, 1);
        chk("left_data", word_data, 6'b101100);
        chk("left_count", bit_count, 0);
        step();
        chk("left_valid_drop", word_valid, 0);

        // Right shift; direction flips after the first bit and must be ignored
        seq6 = 6'b101100;
        direction = 1'b0;
        send_bit(seq6[5]);
        direction = 1'b1;
        for (int i = 4; i >= 0; i--) send_bit(seq6[i]);
        bit_valid = 1'b0;
        chk("right_valid", word_valid, 1);
        chk("right_data", word_data, 6'b001101);
        step();
        chk("right_valid_drop", word_valid, 0);

        // Back-to-back frames with no bubble
        seq12 = 12'b110000_001111;
        for (int i = 11; i >= 0; i--) begin
            send_bit(seq12[i]);
            if (i == 6) begin
                chk("b2b_w1_valid", word_valid, 1);
                chk("b2b_w1_data", word_data, 6'b110000);
            end
            if (i == 5) chk("b2b_gap_valid", word_valid, 0);
        end
        bit_valid = 1'b0;
        chk("b2b_w2_valid", word_valid, 1);
        chk("b2b_w2_data", word_data, 6'b001111);
        step();

        // Stalled consumer: buffer one word, fill the assembly register
        word_ready = 1'b0; direction = 1'b1;
        send_word(6'b111111);
        send_word(6'b010101);
        bit_valid = 1'b0;
        chk("full_data", word_data, 6'h3F);
        chk("full_valid", word_valid, 1);
        chk("full_ready", bit_ready, 0);
        chk("full_count", bit_count, 6);
        chk("full_ovf0", overflow, 0);
        bit_valid = 1'b1;
        step();
        step();
        bit_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("full_hold", word_data, 6'h3F);
        word_ready = 1'b1;
        step();
        chk("drain_data", word_data, 6'b010101);
        chk("drain_valid", word_valid, 1);
        chk("drain_ready", bit_ready, 1);
        chk("drain_count", bit_count, 0);
        step();
        chk("drain2_valid", word_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Flush after a partial frame
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bit_valid = 1'b0;
        chk("part_count", bit_count, 3);
        flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        step();
        flush = 1'b0; bit_valid = 1'b0;
        chk("flush_count", bit_count, 0);
        chk("flush_valid", word_valid, 0);
        send_word(6'b111111);
        bit_valid = 1'b0;
        chk("after_flush_data", word_data, 6'h3F);
        step();

        // Reset mid-frame with a buffered word
        word_ready = 1'b0;
        send_word(6'b100001);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bit_valid = 1'b0;
        chk("pre_rst_data", word_data, 6'h21);
        chk("pre_rst_count", bit_count, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", word_valid, 0);
        chk("mid_rst_count", bit_count, 0);
        chk("mid_rst_ready", bit_ready, 1);
        chk("mid_rst_data", word_data, 0);
        chk("mid_rst_ovf", overflow, 0);

        // Flush in FULL discards the held word, keeps the buffer, no overflow
        send_word(6'b000111);
        send_word(6'b111000);
        bit_valid = 1'b0;
        chk("full2_ready", bit_ready, 0);
        flush = 1'b1; bit_valid = 1'b1;
        step();
        flush = 1'b0; bit_valid = 1'b0;
        chk("fflush_ovf", overflow, 0);
        chk("fflush_ready", bit_ready, 1);
        chk("fflush_count", bit_count, 0);
        chk("fflush_buf", word_data, 6'h07);
        chk("fflush_valid", word_valid, 1);

        // Last bit accepted while the buffered word drains: load + drain
        seq6 = 6'b101010;
        for (int i = 5; i >= 1; i--) send_bit(seq6[i]);
        word_ready = 1'b1;
        send_bit(seq6[0]);
        bit_valid = 1'b0;
        chk("ld_dr_valid", word_valid, 1);
        chk("ld_dr_data", word_data, 6'b101010);
        chk("ld_dr_ready", bit_ready, 1);
        step();
        chk("ld_dr_drop", word_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Receive-side companion of the ALSU shift path. It accepts a serial bit stream one bit per clock and assembles bits into WIDTH-bit parallel words, shifting left or right exactly as the shift unit does. Completed words go out through a valid/ready handshake backed by a one-entry output buffer, so collection can continue while a word waits. The block sits between a serial source and any parallel consumer, such as the ALSU operand path.

## Interface
- WIDTH, 6, word width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- bit_valid  in  1  bit_in is offered this cycle
- bit_in  in  1  serial data bit
- bit_ready  out  1  collector can accept a bit this cycle
- direction  in  1  1 = left (new bit enters LSB), 0 = right (new bit enters MSB); sampled only on first bit of a frame
- flush  in  1  discard the partially or fully assembled frame
- word_valid  out  1  word_data holds a completed word
- word_data  out  WIDTH  completed word
- word_ready  in  1  consumer accepts word this cycle
- bit_count  out  CNT_W  bits held in the assembly register (0..WIDTH)
- overflow  out  1  sticky: bit_valid seen while bit_ready=0

## Operation
- Bit accepted when bit_valid && bit_ready && !flush.
- Left shift: asm <= {asm[WIDTH-2:0], bit_in}; first bit ends in MSB.
- Right shift: asm <= {bit_in, asm[WIDTH-1:1]}; first bit ends in LSB.
- Direction is latched into dir_q when a bit is accepted with bit_count==0. Changes during a frame are ignored.
- FSM states (in shared package):
  - IDLE: count 0.
  - COLLECT: count 1..WIDTH-1.
  - FULL: WIDTH bits held, output buffer occupied.
- IDLE → COLLECT on accept. COLLECT → COLLECT on accept while count < WIDTH-1.
- On accepting the WIDTH-th bit:
  - If the buffer is empty, or is drained this cycle (word_valid && word_ready), load the word into the buffer and go to IDLE.
  - Otherwise go to FULL.
- FULL: bit_ready=0. On buffer drain handshake, move asm into the buffer and go to IDLE.
- bit_ready = (state != FULL).
- Output buffer: word_valid set on load, cleared on handshake with no same-cycle load. word_data holds stable while word_valid && !word_ready.
- flush: state → IDLE, count → 0, asm → 0. A same-cycle bit is dropped and does not set overflow. In FULL the held word is discarded. The output buffer is not affected.
- overflow sets on bit_valid && !bit_ready && !flush. It clears only on rst.
- Reset values: word_valid 0, word_data 0, bit_ready 1, bit_count 0, overflow 0, state IDLE, dir_q 1.

## Timing
- Latency: word_valid rises the cycle after the WIDTH-th bit is accepted.
- Sustained throughput is one bit per clock when word_ready stays high. Back-to-back frames need no bubble.
- Load and drain in the same cycle: word_valid stays 1 and word_data takes the new word.
- FULL → IDLE occurs in the cycle after the drain handshake. bit_ready returns high that same next cycle.
- rst mid-frame: all state returns to reset values on the next edge. The partial frame and any buffered word are lost.
- All outputs are registered except bit_ready, which is decoded from the state register.

## Structure
- Package shift_pkg holds:
  - state enum collect_state_e {IDLE, COLLECT, FULL}
  - constants DIR_LEFT=1'b1 and DIR_RIGHT=1'b0
- Sub-module word_out_slice: a one-entry valid/ready register with load, drain and same-cycle load+drain.
- Top level holds the assembly register, counter, direction latch, FSM and overflow flag.

## Test plan
- Left, word_ready=1, bits 1,0,1,1,0,0 on consecutive cycles → word_data=6'b101100 one cycle after the 6th bit, word_valid high for one cycle.
- Right, same bits → word_data=6'b001101. Toggling direction after the first bit has no effect.
- word_ready=0, 12 continuous bits (all 1s, then 010101 left) → buffer=6'h3F, FULL, bit_ready=0 after the 12th bit. Then raise word_ready: 6'h3F drains, next cycle word_data=6'b010101.
- In FULL, hold bit_valid=1 for two cycles → overflow=1 and stays 1 after the drain. Only rst clears it.
- Accept 3 bits, assert flush, then bits 1,1,1,1,1,1 left → word_data=6'h3F, bit_count reads 0 in the cycle after the flush.
- rst asserted after 4 bits with a word buffered → next cycle word_valid=0, bit_count=0, bit_ready=1, word_data=0.
